cache_backing_memory: RTL and testbench

Backing-store responder for the memory side of the direct-mapped cache. It accepts block reads (4 bytes returned as one 32-bit word) and single-byte write-throughs from the cache's memory port. Each transfer uses a four-phase request/ready handshake with a programmable latency. It sits between the cache and the top level, and replaces the behavioural memory model used in cache benches.

---
 rtl/cache_backing_memory_pkg.sv | 18 +
 rtl/mem_latency_counter.sv | 35 +++
 rtl/cache_backing_memory.sv | 172 +++++++++++++++++
 tb/tb_cache_backing_memory.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_backing_memory_pkg.sv
// Shared constants and state encoding for the cache memory side.
// The cache front end uses the same widths.
package cache_backing_memory_pkg;

  localparam int ADDR_W      = 8;
  localparam int WORD_W      = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int BLOCK_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with a zero flag.
// Holds at zero; a load overrides a decrement.
module mem_latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cache_backing_memory.sv
// Backing store for the cache memory port: block reads, byte
// write-throughs, four-phase handshake with programmable latency.
module cache_backing_memory
  import cache_backing_memory_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MRead_request,
  input  logic               MWrite_request,
  input  logic [ADDR_W-1:0]  MAddress,
  input  logic [WORD_W-1:0]  MWrite_data,
  output logic [BLOCK_W-1:0] MRead_data,
  output logic               MRead_ready,
  output logic               MWrite_done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ?
                        READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  state_e state_q, state_d;

  logic [AW-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CW-1:0]      cnt_val;
  logic               commit;
  logic [AW-1:0]      base;
  logic [BLOCK_W-1:0] rd_word;

  logic [WORD_W-1:0]  mem_q [DEPTH];

  if (AW < ADDR_W) begin : g_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^MAddress[ADDR_W-1:AW];
  end

  mem_latency_counter #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (MWrite_request) begin
          state_d  = ST_WR_WAIT;
          addr_d   = MAddress[AW-1:0];
          wdata_d  = MWrite_data;
          cnt_load = 1'b1;
          cnt_val  = CW'(WRITE_LATENCY - 1);
        end else if (MRead_request) begin
          state_d  = ST_RD_WAIT;
          addr_d   = MAddress[AW-1:0];
          cnt_load = 1'b1;
          cnt_val  = CW'(READ_LATENCY - 1);
        end
      end
      ST_RD_WAIT: begin
        if (!MRead_request)  state_d = ST_IDLE;
        else if (cnt_zero)   state_d = ST_RD_DONE;
        else                 cnt_dec = 1'b1;
      end
      ST_RD_DONE: begin
        if (!MRead_request)  state_d = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (!MWrite_request) state_d = ST_IDLE;
        else if (cnt_zero)   state_d = ST_WR_DONE;
        else                 cnt_dec = 1'b1;
      end
      ST_WR_DONE: begin
        if (!MWrite_request) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d = ready_q;
    done_d  = done_q;
    data_d  = data_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_RD_WAIT: begin
        if (MRead_request && cnt_zero) begin
          ready_d = 1'b1;
          data_d  = rd_word;
        end
      end
      ST_RD_DONE: begin
        if (!MRead_request) ready_d = 1'b0;
      end
      ST_WR_WAIT: begin
        if (MWrite_request && cnt_zero) begin
          done_d = 1'b1;
          commit = 1'b1;
        end
      end
      ST_WR_DONE: begin
        if (!MWrite_request) done_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Block reads ignore the low two address bits.
  assign base = addr_q & ~AW'(3);

  always_comb begin
    rd_word = '0;
    for (int n = 0; n < BLOCK_BYTES; n++) begin
      rd_word[WORD_W*n +: WORD_W] = mem_q[base | AW'(n)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WORD_W'(i);
      end
    end else if (commit) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign MRead_data  = data_q;
  assign MRead_ready = ready_q;
  assign MWrite_done = done_q;

endmodule

// File: tb/tb_cache_backing_memory.sv
// Directed bench for cache_backing_memory: default latencies on
// one instance, WRITE_LATENCY=3 on a second for the abort case.
module tb_cache_backing_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        MRead_request  = 1'b0;
  logic        MWrite_request = 1'b0;
  logic [7:0]  MAddress       = '0;
  logic [7:0]  MWrite_data    = '0;
  logic [31:0] MRead_data;
  logic        MRead_ready;
  logic        MWrite_done;

  logic        r3 = 1'b0;
  logic        w3 = 1'b0;
  logic [7:0]  a3 = '0;
  logic [7:0]  d3 = '0;
  logic [31:0] data3;
  logic        ready3;
  logic        done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_backing_memory dut (
    .clk            (clk),
    .rst            (rst),
    .MRead_request  (MRead_request),
    .MWrite_request (MWrite_request),
    .MAddress       (MAddress),
    .MWrite_data    (MWrite_data),
    .MRead_data     (MRead_data),
    .MRead_ready    (MRead_ready),
    .MWrite_done    (MWrite_done)
  );

  cache_backing_memory #(
    .DEPTH         (64),
    .READ_LATENCY  (2),
    .WRITE_LATENCY (3)
  ) dut3 (
    .clk            (clk),
    .rst            (rst),
    .MRead_request  (r3),
    .MWrite_request (w3),
    .MAddress       (a3),
    .MWrite_data    (d3),
    .MRead_data     (data3),
    .MRead_ready    (ready3),
    .MWrite_done    (done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp,
                    input string tag);
    step();
    MAddress      = a;
    MRead_request = 1'b1;
    step();
    chk({tag, "_k"}, {31'd0, MRead_ready}, 32'd0);
    step();
    chk({tag, "_k1"}, {31'd0, MRead_ready}, 32'd0);
    step();
    chk({tag, "_rdy"}, {31'd0, MRead_ready}, 32'd1);
    chk({tag, "_data"}, MRead_data, exp);
    step();
    chk({tag, "_hold"}, {31'd0, MRead_ready}, 32'd1);
    MRead_request = 1'b0;
    step();
    chk({tag, "_drop"}, {31'd0, MRead_ready}, 32'd0);
    chk({tag, "_keep"}, MRead_data, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input string tag);
    step();
    MAddress       = a;
    MWrite_data    = d;
    MWrite_request = 1'b1;
    step();
    step();
    chk({tag, "_k1"}, {31'd0, MWrite_done}, 32'd0);
    step();
    chk({tag, "_done"}, {31'd0, MWrite_done}, 32'd1);
    MWrite_request = 1'b0;
    step();
    chk({tag, "_drop"}, {31'd0, MWrite_done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, MRead_ready}, 32'd0);
    chk("rst_done", {31'd0, MWrite_done}, 32'd0);
    chk("rst_data", MRead_data, 32'h0000_0000);
    rst = 1'b1;

    rd(8'h05, 32'h0706_0504, "rd05");

    wr(8'h02, 8'hFB, "wr02");
    rd(8'h00, 32'h03FB_0100, "rd00_fb");

    // Write and read together: write wins, read stays pending.
    step();
    MAddress       = 8'h22;
    MWrite_data    = 8'hAB;
    MWrite_request = 1'b1;
    MRead_request  = 1'b1;
    step();
    MAddress = 8'h26;
    step();
    chk("sim_wr_k1", {30'd0, MWrite_done, MRead_ready}, 32'd0);
    step();
    chk("sim_wr_done", {30'd0, MWrite_done, MRead_ready}, 32'd2);
    MWrite_request = 1'b0;
    step();
    chk("sim_wr_drop", {30'd0, MWrite_done, MRead_ready}, 32'd0);
    step();
    step();
    chk("sim_rd_k1", {31'd0, MRead_ready}, 32'd0);
    step();
    chk("sim_rd_rdy", {31'd0, MRead_ready}, 32'd1);
    chk("sim_rd_data", MRead_data, 32'h2726_2524);
    MRead_request = 1'b0;
    step();
    chk("sim_rd_drop", {31'd0, MRead_ready}, 32'd0);
    rd(8'h20, 32'h23AB_2120, "rd20");

    rd(8'h45, 32'h0706_0504, "rd45_wrap");

    // WRITE_LATENCY=3 instance: full write then an aborted one.
    step();
    a3 = 8'h11;
    d3 = 8'h66;
    w3 = 1'b1;
    step();
    step();
    step();
    chk("w3_k2", {31'd0, done3}, 32'd0);
    step();
    chk("w3_done", {31'd0, done3}, 32'd1);
    w3 = 1'b0;
    step();
    chk("w3_drop", {31'd0, done3}, 32'd0);

    step();
    a3 = 8'h12;
    d3 = 8'h55;
    w3 = 1'b1;
    step();
    w3 = 1'b0;
    a3 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", {31'd0, done3}, 32'd0);
    end

    a3 = 8'h10;
    r3 = 1'b1;
    step();
    step();
    chk("abort_rd_k1", {31'd0, ready3}, 32'd0);
    step();
    chk("abort_rd_rdy", {31'd0, ready3}, 32'd1);
    chk("abort_rd_data", data3, 32'h1312_6610);
    r3 = 1'b0;
    step();
    chk("abort_rd_drop", {31'd0, ready3}, 32'd0);

    // Reset in RD_WAIT drops the read and prior writes.
    wr(8'h00, 8'h99, "wr00");
    rd(8'h00, 32'h03FB_0199, "rd00_99");
    step();
    MAddress      = 8'h00;
    MRead_request = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, MRead_ready}, 32'd0);
    chk("mid_rst_data", MRead_data, 32'h0000_0000);
    MRead_request = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_rst_hold", {31'd0, MRead_ready}, 32'd0);
    end
    rst = 1'b1;
    rd(8'h00, 32'h0302_0100, "rd00_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
